// File: rtl/dxi_rx_frame_sink_if.sv
// DXI word stream in, framed word stream out, as seen by the frame sink.
// The slave modport is the sink's view; the master modport is the view of whatever surrounds it.
interface dxi_rx_frame_sink_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_err
  );
endinterface

// File: rtl/dxi_rx_frame_sink.sv
// DXI responder: throttled word intake, frame-length policing, FWFT FIFO buffering
// and registered delivery of framed words to the downstream consumer.
module dxi_rx_frame_sink #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned READY_PCT = 100
) (
  input  logic               clk,
  input  logic               rst,
  dxi_rx_frame_sink_if.slave dxi,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = 16;
  localparam int unsigned TW = 7;

  typedef struct packed {
    logic              err;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } state_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  state_t        state, state_n;
  logic [LW-1:0] len_cnt, len_cnt_n, len_inc;
  logic [TW-1:0] thr_cnt;
  logic [15:0]   drop_cnt_n;
  logic          rst_q;
  logic          thr_ok, full, empty, empty_n;
  logic          s_ready_c, accept, pop, push;
  entry_t        wr_entry, head_n;

  assign dxi.s_ready = s_ready_c;

  // Intake decision, frame policing and the FIFO head that will be presented next cycle.
  always_comb begin
    thr_ok     = thr_cnt < TW'(READY_PCT);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty      = wr_ptr == rd_ptr;
    s_ready_c  = !rst_q && thr_ok && (!full || state == DROP);
    accept     = dxi.s_valid && s_ready_c;
    pop        = !empty && dxi.m_ready;
    len_inc    = len_cnt + LW'(1);

    push       = 1'b0;
    wr_entry   = '{err: 1'b0, last: dxi.s_last, data: dxi.s_data};
    state_n    = state;
    len_cnt_n  = len_cnt;
    drop_cnt_n = drop_cnt;

    case (state)
      IDLE: begin
        if (accept) begin
          push      = 1'b1;
          len_cnt_n = LW'(1);
          state_n   = dxi.s_last ? IDLE : FRAME;
        end
      end
      FRAME: begin
        if (accept) begin
          push      = 1'b1;
          len_cnt_n = len_inc;
          if (dxi.s_last) begin
            state_n   = IDLE;
            len_cnt_n = '0;
          end else if (len_inc == LW'(MAX_LEN)) begin
            // Truncate: close the frame here and mark it errored.
            wr_entry.last = 1'b1;
            wr_entry.err  = 1'b1;
            state_n       = DROP;
            len_cnt_n     = '0;
          end
        end
      end
      DROP: begin
        if (accept) begin
          if (drop_cnt != 16'hFFFF) drop_cnt_n = drop_cnt + 16'd1;
          if (dxi.s_last) begin
            state_n   = IDLE;
            len_cnt_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    wr_ptr_n = wr_ptr + PW'(push);
    rd_ptr_n = rd_ptr + PW'(pop);
    empty_n  = wr_ptr_n == rd_ptr_n;
    // A word written into an otherwise-drained FIFO becomes the head directly.
    head_n   = (push && (rd_ptr_n == wr_ptr)) ? wr_entry : mem[rd_ptr_n[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      len_cnt     <= '0;
      thr_cnt     <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      dxi.m_valid <= 1'b0;
      dxi.m_data  <= '0;
      dxi.m_last  <= 1'b0;
      dxi.m_err   <= 1'b0;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      state       <= state_n;
      len_cnt     <= len_cnt_n;
      drop_cnt    <= drop_cnt_n;
      thr_cnt     <= (thr_cnt == TW'(99)) ? '0 : thr_cnt + TW'(1);
      dxi.m_valid <= !empty_n;
      if (!empty_n) begin
        dxi.m_data <= head_n.data;
        dxi.m_last <= head_n.last;
        dxi.m_err  <= head_n.err;
      end
      if (pop && dxi.m_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dxi_rx_frame_sink.sv
// Bench for dxi_rx_frame_sink: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, throttle pattern check.
module tb_dxi_rx_frame_sink;
  localparam int unsigned DW      = 16;
  localparam int unsigned DEPTH_A = 8;
  localparam int unsigned MAXL_A  = 4;
  localparam int unsigned PCT_A   = 100;
  localparam int unsigned PCT_B   = 25;

  typedef struct packed {
    logic          err;
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [15:0] frame_cnt_a, drop_cnt_a, frame_cnt_b, drop_cnt_b;

  dxi_rx_frame_sink_if #(.DATA_W(DW)) ifa ();
  dxi_rx_frame_sink_if #(.DATA_W(DW)) ifb ();

  dxi_rx_frame_sink #(.DATA_W(DW), .DEPTH(DEPTH_A), .MAX_LEN(MAXL_A), .READY_PCT(PCT_A)) dut_a (
    .clk(clk), .rst(rst_a), .dxi(ifa), .frame_cnt(frame_cnt_a), .drop_cnt(drop_cnt_a)
  );

  dxi_rx_frame_sink #(.DATA_W(DW), .DEPTH(8), .MAX_LEN(64), .READY_PCT(PCT_B)) dut_b (
    .clk(clk), .rst(rst_b), .dxi(ifb), .frame_cnt(frame_cnt_b), .drop_cnt(drop_cnt_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference model of dut_a: what has been accepted but not yet delivered, plus counters.
  ent_t        q[$];
  ent_t        hold;
  bit          armed = 1'b0;
  bit          mdl_rst_q;
  bit          mdl_dropping;
  int          mdl_cyc, mdl_len, acc_cnt, err_seen;
  int unsigned mdl_frames, mdl_drops;
  bit          exp_ready, do_pop, do_acc;
  ent_t        head, e;

  always @(negedge clk) begin
    exp_ready = 1'b0;
    if (armed) begin
      exp_ready = !mdl_rst_q && ((mdl_cyc % 100) < PCT_A) &&
                  ((q.size() < DEPTH_A) || mdl_dropping);
      head = (q.size() != 0) ? q[0] : hold;
      chk("s_ready",   32'(ifa.s_ready), 32'(exp_ready));
      chk("m_valid",   32'(ifa.m_valid), 32'(q.size() != 0));
      chk("m_data",    32'(ifa.m_data),  32'(head.data));
      chk("m_last",    32'(ifa.m_last),  32'(head.last));
      chk("m_err",     32'(ifa.m_err),   32'(head.err));
      chk("frame_cnt", 32'(frame_cnt_a), mdl_frames % 65536);
      chk("drop_cnt",  32'(drop_cnt_a),  mdl_drops);
    end
    if (rst_a) begin
      q.delete();
      hold = '0; mdl_rst_q = 1'b1; mdl_dropping = 1'b0;
      mdl_cyc = 0; mdl_len = 0; mdl_frames = 0; mdl_drops = 0;
      armed = 1'b1;
    end else if (armed) begin
      do_pop = (q.size() != 0) && ifa.m_ready;
      do_acc = ifa.s_valid && exp_ready;
      if (do_pop) begin
        hold = q.pop_front();
        if (hold.last) mdl_frames++;
        if (hold.last && hold.err) err_seen++;
      end
      if (do_acc) begin
        acc_cnt++;
        if (mdl_dropping) begin
          if (mdl_drops < 65535) mdl_drops++;
          if (ifa.s_last) mdl_dropping = 1'b0;
        end else begin
          mdl_len++;
          e = '{err: 1'b0, last: ifa.s_last, data: ifa.s_data};
          if (ifa.s_last) mdl_len = 0;
          else if (mdl_len == MAXL_A) begin
            e.last = 1'b1; e.err = 1'b1; mdl_dropping = 1'b1; mdl_len = 0;
          end
          q.push_back(e);
        end
      end
      mdl_cyc++;
      mdl_rst_q = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit last, output int tries);
    logic r;
    tries = 0;
    ifa.s_valid = 1'b1; ifa.s_data = d; ifa.s_last = last;
    while (1) begin
      @(negedge clk);
      r = ifa.s_ready;
      @(posedge clk); #1;
      if (r) break;
      tries++;
      if (tries > 3000) begin timeout_fail("send"); break; end
    end
    ifa.s_valid = 1'b0;
  endtask

  task automatic drain();
    ifa.m_ready = 1'b1;
    for (int t = 0; t < 500 && q.size() != 0; t++) idle(1);
    if (q.size() != 0) timeout_fail("drain");
    idle(1);
  endtask

  bit          rnd_on;
  int          tr, stalls, acc0, highs;
  logic        rb;
  logic [15:0] bdata, exp_pop;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0; ifa.m_ready = 1'b1;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b1; ifb.m_ready = 1'b1;
    acc_cnt = 0; err_seen = 0;
    idle(3);
    rst_a = 1'b0;
    chk("reset_m_valid", 32'(ifa.m_valid), 0);
    chk("reset_s_ready", 32'(ifa.s_ready), 0);

    // Three-word frame through an idle sink.
    send(16'hA1, 1'b0, tr); send(16'hA2, 1'b0, tr); send(16'hA3, 1'b1, tr);
    drain();
    chk("t1_frame_cnt", 32'(frame_cnt_a), 1);
    chk("t1_tail_data", 32'(ifa.m_data), 32'h00A3);

    // Twelve single-word frames into a stalled consumer.
    ifa.m_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      for (int i = 0; i < 12; i++) send(16'h0200 + 16'(i), 1'b1, tr);
      begin
        idle(30);
        chk("t2_full_s_ready", 32'(ifa.s_ready), 0);
        chk("t2_accepts_at_full", acc_cnt - acc0, 8);
        ifa.m_ready = 1'b1;
      end
    join
    drain();
    chk("t2_frame_cnt", 32'(frame_cnt_a), 13);

    // Six-word frame against a four-word limit, then a clean frame.
    for (int i = 0; i < 6; i++) send(16'h0300 + 16'(i), i == 5, tr);
    drain();
    chk("t3_drop_cnt", 32'(drop_cnt_a), 2);
    chk("t3_err_frames", err_seen, 1);
    send(16'h0310, 1'b0, tr); send(16'h0311, 1'b1, tr);
    drain();
    chk("t3_clean_err", 32'(ifa.m_err), 0);
    chk("t3_clean_data", 32'(ifa.m_data), 32'h0311);
    chk("t3_frame_cnt", 32'(frame_cnt_a), 15);

    // Reset with five words buffered and a frame left open.
    ifa.m_ready = 1'b0;
    send(16'h0500, 1'b0, tr); send(16'h0501, 1'b0, tr); send(16'h0502, 1'b1, tr);
    send(16'h0503, 1'b0, tr); send(16'h0504, 1'b0, tr);
    idle(2);
    chk("t5_buffered", q.size(), 5);
    rst_a = 1'b1;
    idle(1);
    rst_a = 1'b0;
    chk("t5_m_valid", 32'(ifa.m_valid), 0);
    chk("t5_s_ready", 32'(ifa.s_ready), 0);
    chk("t5_frame_cnt", 32'(frame_cnt_a), 0);
    chk("t5_drop_cnt", 32'(drop_cnt_a), 0);
    ifa.m_ready = 1'b1;
    send(16'h0510, 1'b0, tr); send(16'h0511, 1'b1, tr);
    drain();
    chk("t5_after_frames", 32'(frame_cnt_a), 1);
    chk("t5_after_data", 32'(ifa.m_data), 32'h0511);

    // Occupancy held at seven by simultaneous push and pop.
    ifa.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h0600 + 16'(i), 1'b1, tr);
    ifa.m_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      send(16'h0700 + 16'(i), 1'b1, tr);
      stalls += tr;
    end
    chk("t6_stalls", stalls, 0);
    drain();
    chk("t6_frame_cnt", 32'(frame_cnt_a), 28);

    // Random frames, gaps and consumer backpressure.
    rnd_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          int len;
          len = $urandom_range(1, 7);
          for (int w = 0; w < len; w++) begin
            idle($urandom_range(0, 2));
            send(16'($urandom), w == len - 1, tr);
          end
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk); #1;
        ifa.m_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
    chk("rnd_frame_cnt", 32'(frame_cnt_a), 88);

    // Throttled sink: s_valid held high, ready allowed for thr_cnt 0..24 only.
    rst_b = 1'b0;
    bdata = '0; exp_pop = '0; highs = 0;
    ifb.s_valid = 1'b1; ifb.s_data = bdata;
    for (int c = 0; c < 303; c++) begin
      @(negedge clk);
      rb = ifb.s_ready;
      if (c < 300) chk("t4_ready_phase", 32'(rb), 32'(((c % 100) < 25) && (c != 0)));
      if (c >= 100 && c < 300 && rb) highs++;
      if (ifb.m_valid) begin
        chk("t4_order", 32'(ifb.m_data), 32'(exp_pop));
        exp_pop++;
      end
      @(posedge clk); #1;
      if (rb && ifb.s_valid) begin
        bdata++;
        ifb.s_data = bdata;
      end
      if (c == 299) ifb.s_valid = 1'b0;
    end
    chk("t4_high_cycles", highs, 50);
    chk("t4_no_loss", 32'(exp_pop), 32'(bdata));
    chk("t4_frame_cnt", 32'(frame_cnt_b), 32'(bdata));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
